free_list: RTL and testbench

- Circular FIFO of free physical-register IDs for the rename stage. Rename dequeues one free physical register (pd) per renamed instruction whose rd is nonzero.
- The commit stage enqueues the stale physical register released on each retiring instruction whose rd is nonzero.
- On a commit-time flush, the block restores itself in one cycle to "every register not in the retirement map is free". It does this by rewinding the read pointer; it does not reload any contents.

---
 rtl/free_list.sv | 84 ++++++++
 tb/tb_free_list.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/free_list.sv
// Circular FIFO of free physical-register IDs feeding rename; commit returns
// stale IDs, and a flush rewinds the read pointer so every unmapped ID is free.
module free_list #(
  parameter int NUM_PR = 64,
  parameter int NUM_AR = 32,
  parameter int DEPTH  = NUM_PR - NUM_AR,
  localparam int PR_WIDTH = $clog2(NUM_PR),
  localparam int IDX_W    = $clog2(DEPTH),
  localparam int PTR_W    = IDX_W + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enqueue,
  input  logic [PR_WIDTH-1:0] wdata,
  input  logic                dequeue,
  output logic [PR_WIDTH-1:0] rdata,
  output logic                empty,
  output logic                full,
  output logic [PTR_W-1:0]    count,
  input  logic                flush,
  output logic                overflow_err
);

  // Handshake: there is no ready back-pressure. dequeue takes rdata in the
  // same cycle and is honoured only when !empty && !flush (rename must stall
  // on empty); enqueue is honoured when !full or alongside an honoured dequeue.

  logic [PR_WIDTH-1:0] mem_q [DEPTH];
  logic [PR_WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic                overflow_err_q, overflow_err_d;

  logic             deq_ok;
  logic             enq_ok;
  logic [PTR_W-1:0] wr_next;

  always_comb begin
    empty = (rd_ptr_q == wr_ptr_q);
    full  = (rd_ptr_q[IDX_W-1:0] == wr_ptr_q[IDX_W-1:0]) &&
            (rd_ptr_q[IDX_W] != wr_ptr_q[IDX_W]);
    count = wr_ptr_q - rd_ptr_q;
    rdata = mem_q[rd_ptr_q[IDX_W-1:0]];
    overflow_err = overflow_err_q;
  end

  always_comb begin
    deq_ok  = dequeue && !empty && !flush;
    enq_ok  = enqueue && (!full || deq_ok);
    wr_next = wr_ptr_q + {{(PTR_W-1){1'b0}}, enq_ok};

    mem_d = mem_q;
    if (enq_ok) begin
      mem_d[wr_ptr_q[IDX_W-1:0]] = wdata;
    end

    wr_ptr_d = wr_next;
    rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, deq_ok};
    // Squashed allocations are still in storage; flipping the wrap bit of the
    // post-enqueue write pointer reclaims them all as free again.
    if (flush) begin
      rd_ptr_d = {~wr_next[IDX_W], wr_next[IDX_W-1:0]};
    end

    overflow_err_d = overflow_err_q || (enqueue && full && !deq_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= PR_WIDTH'(NUM_AR + i);
      end
      rd_ptr_q       <= '0;
      wr_ptr_q       <= PTR_W'(DEPTH);
      overflow_err_q <= 1'b0;
    end else begin
      mem_q          <= mem_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      overflow_err_q <= overflow_err_d;
    end
  end

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: reset image, drain, empty corner cases,
// wrap-around streaming, flush rewind, overflow and asynchronous reset.
module tb_free_list;

  logic       clk;
  logic       rst;
  logic       enqueue;
  logic [5:0] wdata;
  logic       dequeue;
  logic [5:0] rdata;
  logic       empty;
  logic       full;
  logic [5:0] count;
  logic       flush;
  logic       overflow_err;

  int checks;
  int errors;
  logic [5:0] exp_q[$];
  logic [5:0] wd;

  free_list dut (
    .clk          (clk),
    .rst          (rst),
    .enqueue      (enqueue),
    .wdata        (wdata),
    .dequeue      (dequeue),
    .rdata        (rdata),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .flush        (flush),
    .overflow_err (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of requests, then sample 1 time unit after the edge.
  task automatic cycle(input logic enq, input logic [5:0] wd_i, input logic deq, input logic fl);
    enqueue = enq;
    wdata   = wd_i;
    dequeue = deq;
    flush   = fl;
    @(posedge clk);
    #1;
    enqueue = 1'b0;
    dequeue = 1'b0;
    flush   = 1'b0;
    wdata   = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_full"}, full, 1);
    check({tag, "_empty"}, empty, 0);
    check({tag, "_count"}, count, 32);
    check({tag, "_rdata"}, rdata, 32);
    check({tag, "_ovf"}, overflow_err, 0);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    enqueue = 1'b0;
    dequeue = 1'b0;
    flush   = 1'b0;
    wdata   = '0;
    #12;
    rst = 1'b0;
    #1;

    // Reset image and full drain in order.
    check_reset_outputs("reset");
    for (int i = 0; i < 32; i++) begin
      check("drain_rdata", rdata, 32 + i);
      cycle(1'b0, 6'd0, 1'b1, 1'b0);
    end
    check("drained_empty", empty, 1);
    check("drained_count", count, 0);
    check("drained_full", full, 0);

    // Dequeue while empty is ignored.
    cycle(1'b0, 6'd0, 1'b1, 1'b0);
    check("deq_empty_count", count, 0);
    check("deq_empty_empty", empty, 1);

    // Enqueue + dequeue from empty: only the enqueue lands.
    cycle(1'b1, 6'd40, 1'b1, 1'b0);
    check("enq_from_empty_count", count, 1);
    check("enq_from_empty_rdata", rdata, 40);
    check("enq_from_empty_empty", empty, 0);

    // Asynchronous reset between edges.
    cycle(1'b1, 6'd11, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    #1;
    rst = 1'b0;

    // Five allocations, then 40 cycles of paired traffic across the wrap.
    for (int i = 0; i < 5; i++) cycle(1'b0, 6'd0, 1'b1, 1'b0);
    check("five_deq_count", count, 27);
    exp_q.delete();
    for (int i = 37; i < 64; i++) exp_q.push_back(6'(i));
    for (int k = 0; k < 40; k++) begin
      wd = 6'((k * 5 + 1) % 64);
      check("stream_rdata", rdata, exp_q[0]);
      cycle(1'b1, wd, 1'b1, 1'b0);
      void'(exp_q.pop_front());
      exp_q.push_back(wd);
      check("stream_count", count, 27);
    end

    // Flush rewind after ten allocations, with enqueue and dequeue present.
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b0, 6'd0, 1'b1, 1'b0);
    check("pre_flush_rdata", rdata, 42);
    check("pre_flush_count", count, 22);
    cycle(1'b1, 6'd7, 1'b1, 1'b1);
    check("flush_full", full, 1);
    check("flush_count", count, 32);
    check("flush_empty", empty, 0);
    exp_q.delete();
    for (int i = 33; i < 64; i++) exp_q.push_back(6'(i));
    exp_q.push_back(6'd7);
    for (int i = 0; i < 32; i++) begin
      check("post_flush_rdata", rdata, exp_q[i]);
      cycle(1'b0, 6'd0, 1'b1, 1'b0);
    end
    check("post_flush_empty", empty, 1);
    check("post_flush_ovf", overflow_err, 0);

    // Flush alone from empty makes the list full again.
    cycle(1'b0, 6'd0, 1'b0, 1'b1);
    check("flush_empty_full", full, 1);
    check("flush_empty_count", count, 32);
    check("flush_empty_rdata", rdata, 33);

    // Overflow: enqueue alone while full is dropped and sticky.
    cycle(1'b1, 6'd5, 1'b0, 1'b0);
    check("ovf_set", overflow_err, 1);
    check("ovf_count", count, 32);
    check("ovf_rdata", rdata, 33);
    cycle(1'b0, 6'd0, 1'b0, 1'b0);
    check("ovf_sticky", overflow_err, 1);
    cycle(1'b0, 6'd0, 1'b0, 1'b1);
    check("ovf_after_flush", overflow_err, 1);

    // Paired enqueue/dequeue while full is accepted.
    cycle(1'b1, 6'd9, 1'b1, 1'b0);
    check("full_pair_count", count, 32);
    check("full_pair_full", full, 1);
    exp_q.delete();
    for (int i = 34; i < 64; i++) exp_q.push_back(6'(i));
    exp_q.push_back(6'd7);
    exp_q.push_back(6'd9);
    for (int i = 0; i < 32; i++) begin
      check("full_pair_drain", rdata, exp_q[i]);
      cycle(1'b0, 6'd0, 1'b1, 1'b0);
    end
    check("full_pair_drain_empty", empty, 1);

    // Only reset clears the error flag.
    do_reset();
    check_reset_outputs("final_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
